keypad_scanner_4x4: RTL and testbench

Input-side companion to the multiplexed 4-digit display driver. It scans a 4x4 matrix keypad one row at a time, using the same strobing scheme as the display (active-low one-hot row select), and reads the four active-low column lines. It debounces whole-matrix snapshots and emits one key code per press over a valid/ready handshake to the time-setting logic.

---
 rtl/keypad_scanner_4x4.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scanner_4x4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: row-strobed 4x4 matrix keypad scanner with whole-matrix
// debounce, single-key press detection and a one-entry valid/ready output buffer.
// Optional auto-repeat of a held key is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner_4x4 #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int SCAN_HZ        = 4000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_SCANS = 500,
  parameter int REPEAT_RATE_SCANS  = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_sel,
  input  logic [3:0] col_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_pressed,
  output logic       overflow
);

  localparam int DWELL_RAW = CLK_FREQ / SCAN_HZ;
  localparam int DWELL     = (DWELL_RAW < 4) ? 4 : DWELL_RAW;
  localparam int DW        = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [3:0]    DEB        = 4'(DEBOUNCE_SCANS);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [3:0]    r_rowSel;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [15:0]   r_snap;
  logic [15:0]   r_prevSnap;
  logic [15:0]   r_stable;
  logic [15:0]   r_prevStable;
  logic [3:0]    r_debCnt;
  logic          r_scanDone;
  logic          r_stableUpd;
  logic          r_lock;
  logic          r_keyPressed;
  logic [3:0]    r_keyCode;
  logic          r_keyValid;
  logic          r_overflow;

  logic          w_rowDone;
  logic [1:0]    w_nextRow;
  logic [3:0]    w_nextCnt;
  logic          w_loadStable;
  logic          w_oneHot;
  logic [3:0]    w_stableCode;
  logic          w_pressEvent;
  logic          w_repEvent;
  logic          w_event;

  // Index of the set bit; only meaningful when exactly one bit is set.
  function automatic logic [3:0] encode(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign w_rowDone    = (r_dwell == DWELL_LAST);
  assign w_nextRow    = r_row + 2'd1;
  assign w_nextCnt    = (r_snap != r_prevSnap) ? 4'd1 :
                        (r_debCnt >= DEB)      ? DEB  : r_debCnt + 4'd1;
  assign w_loadStable = r_scanDone && (w_nextCnt == DEB);
  assign w_oneHot     = (r_stable != 16'd0) && ((r_stable & (r_stable - 16'd1)) == 16'd0);
  assign w_stableCode = encode(r_stable);
  assign w_pressEvent = r_stableUpd && w_oneHot && (r_prevStable == 16'd0) && !r_lock;
  assign w_event      = w_pressEvent || w_repEvent;

  // Two-flop synchronizer on the raw columns, inverted so 1 means pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~col_in;
      r_sync2 <= r_sync1;
    end
  end

  // Row strobe: sample the columns at the end of each dwell, then step to the next row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell    <= '0;
      r_row      <= '0;
      r_rowSel   <= 4'b1110;
      r_snap     <= '0;
      r_scanDone <= 1'b0;
    end else begin
      r_scanDone <= 1'b0;
      if (w_rowDone) begin
        r_dwell                    <= '0;
        r_row                      <= w_nextRow;
        r_rowSel                   <= ~(4'b0001 << w_nextRow);
        r_snap[{r_row, 2'b00} +: 4] <= r_sync2;
        r_scanDone                 <= (r_row == 2'd3);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  // Whole-matrix debounce: the stable matrix follows a snapshot repeated DEB scans in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_debCnt     <= '0;
      r_prevSnap   <= '0;
      r_stable     <= '0;
      r_prevStable <= '0;
      r_stableUpd  <= 1'b0;
    end else begin
      r_stableUpd <= 1'b0;
      if (r_scanDone) begin
        r_debCnt   <= w_nextCnt;
        r_prevSnap <= r_snap;
        if (w_loadStable) begin
          r_prevStable <= r_stable;
          r_stable     <= r_snap;
          r_stableUpd  <= 1'b1;
        end
      end
    end
  end

  // Multi-key lockout holds until the stable matrix is fully released; also tracks key_pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock       <= 1'b0;
      r_keyPressed <= 1'b0;
    end else begin
      r_keyPressed <= |r_stable;
      if (r_stableUpd) begin
        if (r_stable == 16'd0) r_lock <= 1'b0;
        else if (!w_oneHot)    r_lock <= 1'b1;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                           REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] r_repCnt;
  logic          r_repStarted;
  logic          r_repEvent;
  logic [RW-1:0] w_repTarget;
  logic          w_stableChg;

  assign w_repTarget = r_repStarted ? RW'(REPEAT_RATE_SCANS) : RW'(REPEAT_DELAY_SCANS);
  assign w_stableChg = w_loadStable && (r_snap != r_stable);
  assign w_repEvent  = r_repEvent;

  // Count scans while a single unlocked key is held; fire the first repeat after the delay, then at the rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_repCnt     <= '0;
      r_repStarted <= 1'b0;
      r_repEvent   <= 1'b0;
    end else begin
      r_repEvent <= 1'b0;
      if (w_stableChg) begin
        r_repCnt     <= '0;
        r_repStarted <= 1'b0;
      end else if (r_scanDone && w_oneHot && !r_lock) begin
        if (r_repCnt + RW'(1) == w_repTarget) begin
          r_repCnt     <= '0;
          r_repStarted <= 1'b1;
          r_repEvent   <= 1'b1;
        end else begin
          r_repCnt <= r_repCnt + RW'(1);
        end
      end
    end
  end
`else
  assign w_repEvent = 1'b0;
`endif

  // Single-entry output buffer: accept an event if empty or draining this cycle, else flag overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keyCode  <= '0;
      r_keyValid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_event) begin
        if (!r_keyValid || key_ready) begin
          r_keyCode  <= w_stableCode;
          r_keyValid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_keyValid && key_ready) begin
        r_keyValid <= 1'b0;
      end
    end
  end

  assign row_sel     = r_rowSel;
  assign key_code    = r_keyCode;
  assign key_valid   = r_keyValid;
  assign key_pressed = r_keyPressed;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb_keypad_scanner_4x4: directed bench for keypad_scanner_4x4 with a
// behavioural 4x4 matrix model (DWELL=10, four-scan debounce).
module tb_keypad_scanner_4x4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rowSel;
  logic [3:0]  colIn;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyReady = 1'b1;
  logic        keyPressed;
  logic        overflow;
  logic [15:0] keys = 16'h0000;

  int          checks    = 0;
  int          errors    = 0;
  int          xferCount = 0;
  int          ovfCount  = 0;
  logic [3:0]  lastCode  = 4'h0;
  int          base;
  int          baseOvf;
  logic [3:0]  expSel;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  keypad_scanner_4x4 #(
    .CLK_FREQ      (1000),
    .SCAN_HZ       (100),
    .DEBOUNCE_SCANS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_sel    (rowSel),
    .col_in     (colIn),
    .key_code   (keyCode),
    .key_valid  (keyValid),
    .key_ready  (keyReady),
    .key_pressed(keyPressed),
    .overflow   (overflow)
  );

  // Matrix model: a pressed key pulls its column low while its row is strobed
  always_comb begin
    colIn = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!rowSel[r]) colIn = colIn & ~keys[4*r +: 4];
    end
  end

  // Record every handshake transfer and every overflow pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (keyValid && keyReady) begin
        xferCount = xferCount + 1;
        lastCode  = keyCode;
      end
      if (overflow) ovfCount = ovfCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] pattern);
    @(negedge clk);
    keys = pattern;
  endtask

  // Ready only changes just after a rising edge so it never races the negedge monitor
  task automatic setReady(input logic value);
    @(posedge clk);
    #1 keyReady = value;
  endtask

  task automatic waitXfer(input string tag, input int target, input int limit);
    for (int i = 0; i < limit && xferCount < target; i++) @(negedge clk);
    checkOutput(tag, 16'(xferCount), 16'(target));
  endtask

  task automatic waitValid(input string tag, input int limit);
    for (int i = 0; i < limit && !keyValid; i++) @(negedge clk);
    checkOutput(tag, 16'(keyValid), 16'd1);
  endtask

  // Directed scenario sequence
  initial begin
    $display("[TB] start");

    // Reset then idle: row strobe steps every 10 cycles, nothing reported
    repeat (3) @(negedge clk);
    checkOutput("rst_rowSel", 16'(rowSel), 16'h000E);
    checkOutput("rst_keyCode", 16'(keyCode), 16'h0);
    checkOutput("rst_keyValid", 16'(keyValid), 16'h0);
    checkOutput("rst_keyPressed", 16'(keyPressed), 16'h0);
    checkOutput("rst_overflow", 16'(overflow), 16'h0);
    rst = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      expSel = ~(4'b0001 << ((k / 10) % 4));
      checkOutput("s1_rowSel", 16'(rowSel), 16'(expSel));
      checkOutput("s1_keyValid", 16'(keyValid), 16'h0);
      checkOutput("s1_keyPressed", 16'(keyPressed), 16'h0);
    end

    // Clean press of row 2 / col 1 gives one event with code 9
    base = xferCount;
    applyStimulus(16'h0200);
    waitCycles(100);
    checkOutput("s2_early", 16'(xferCount), 16'(base));
    waitXfer("s2_xfer", base + 1, 300);
    checkOutput("s2_code", 16'(lastCode), 16'h9);
    checkOutput("s2_pressed", 16'(keyPressed), 16'h1);
    waitCycles(1000);
    checkOutput("s2_noRepeat", 16'(xferCount), 16'(base + 1));
    checkOutput("s2_holdPressed", 16'(keyPressed), 16'h1);
    applyStimulus(16'h0000);
    waitCycles(300);
    checkOutput("s2_released", 16'(keyPressed), 16'h0);
    checkOutput("s2_validLow", 16'(keyValid), 16'h0);
    checkOutput("s2_count", 16'(xferCount), 16'(base + 1));

    // Bounce on row 0 / col 0 from a fresh scan phase, then a clean hold
    base = xferCount;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      keys = ((i / 7) % 2 == 0) ? 16'h0001 : 16'h0000;
      @(negedge clk);
    end
    keys = 16'h0001;
    checkOutput("s3_noBounceEvent", 16'(xferCount), 16'(base));
    waitXfer("s3_xfer", base + 1, 300);
    checkOutput("s3_code", 16'(lastCode), 16'h0);
    waitCycles(200);
    checkOutput("s3_single", 16'(xferCount), 16'(base + 1));
    applyStimulus(16'h0000);
    waitCycles(300);

    // Consumer stalled: first code held, second event dropped with overflow
    base    = xferCount;
    baseOvf = ovfCount;
    setReady(1'b0);
    applyStimulus(16'h0008);
    waitValid("s4_valid", 300);
    checkOutput("s4_code", 16'(keyCode), 16'h3);
    applyStimulus(16'h0000);
    waitCycles(300);
    checkOutput("s4_holdValid", 16'(keyValid), 16'h1);
    checkOutput("s4_holdCode", 16'(keyCode), 16'h3);
    checkOutput("s4_noOvfYet", 16'(ovfCount), 16'(baseOvf));
    applyStimulus(16'h1000);
    waitCycles(300);
    checkOutput("s4_ovfOnce", 16'(ovfCount), 16'(baseOvf + 1));
    checkOutput("s4_stillValid", 16'(keyValid), 16'h1);
    checkOutput("s4_codeKept", 16'(keyCode), 16'h3);
    setReady(1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("s4_drained", 16'(keyValid), 16'h0);
    checkOutput("s4_codeAfter", 16'(keyCode), 16'h3);
    waitCycles(100);
    checkOutput("s4_xfer", 16'(xferCount), 16'(base + 1));
    checkOutput("s4_xferCode", 16'(lastCode), 16'h3);
    applyStimulus(16'h0000);
    waitCycles(300);

    // Two keys together lock out, partial release stays silent, clean press recovers
    base = xferCount;
    applyStimulus(16'h0420);
    waitCycles(300);
    checkOutput("s5_dual", 16'(xferCount), 16'(base));
    checkOutput("s5_dualPressed", 16'(keyPressed), 16'h1);
    applyStimulus(16'h0020);
    waitCycles(300);
    checkOutput("s5_partial", 16'(xferCount), 16'(base));
    applyStimulus(16'h0000);
    waitCycles(300);
    checkOutput("s5_released", 16'(keyPressed), 16'h0);
    applyStimulus(16'h0020);
    waitXfer("s5_xfer", base + 1, 300);
    checkOutput("s5_code", 16'(lastCode), 16'h5);
    applyStimulus(16'h0000);
    waitCycles(300);

    // Reset during debounce restarts the scan and the debounce count
    base = xferCount;
    applyStimulus(16'h0040);
    waitCycles(100);
    checkOutput("s6_beforeRst", 16'(xferCount), 16'(base));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s6_rowSel", 16'(rowSel), 16'h000E);
    checkOutput("s6_keyValid", 16'(keyValid), 16'h0);
    checkOutput("s6_keyPressed", 16'(keyPressed), 16'h0);
    checkOutput("s6_overflow", 16'(overflow), 16'h0);
    checkOutput("s6_keyCode", 16'(keyCode), 16'h0);
    rst = 1'b0;
    waitCycles(130);
    checkOutput("s6_freshDebounce", 16'(xferCount), 16'(base));
    waitXfer("s6_xfer", base + 1, 200);
    checkOutput("s6_code", 16'(lastCode), 16'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
